// File: rtl/regwb_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package regwb_pkg;

    localparam int         ADDR_W  = 5;
    localparam int         DATA_W  = 48;
    localparam logic [4:0] R0_ADDR = 5'd0;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the first set req bit at or after ptr
// (wrapping) wins; gnt is one-hot and gnt_idx is its index.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    always_comb begin
        logic             found;
        int               sum;
        logic [IDX_W-1:0] idx;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sum     = 0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            sum = (int'(ptr) + i) % N;
            idx = IDX_W'(sum);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a
// drain/halt handshake. Per-requester stall counters: REGWB_PERF_CNT_EN.
module regfile_wb_arbiter
    import regwb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = regwb_pkg::ADDR_W,
    parameter int DATA_W  = regwb_pkg::DATA_W,
    parameter int PERF_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      drain_req,
    output logic                      drain_done,
    output logic                      wb_enable,
    output logic [ADDR_W-1:0]         wb_addr,
    output logic [DATA_W-1:0]         wb_data,
    output logic                      rel_enable,
    output logic [ADDR_W-1:0]         rel_addr,
    output logic [NUM_REQ*PERF_W-1:0] perf_stall_cnt
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               wb_enable_q, wb_enable_d;
    logic [ADDR_W-1:0]  wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0]  wb_data_q, wb_data_d;

    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               granted;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;

    rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Grants only in RUN, and never in the cycle drain_req is first seen.
    always_comb begin
        req_ready = ((state_q == RUN) && !drain_req) ? gnt : '0;
        granted   = |req_ready;
        sel_addr  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
        sel_data  = req_data[int'(gnt_idx)*DATA_W +: DATA_W];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (drain_req)    state_d = DRAIN;
            DRAIN:   if (!wb_enable_q) state_d = HALTED;
            HALTED:  if (!drain_req)   state_d = RUN;
            default:                   state_d = RUN;
        endcase
    end

    // R0 writes still consume a grant and update addr/data, but never
    // raise the write or release strobes.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        wb_enable_d = 1'b0;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        if (granted) begin
            rr_ptr_d    = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            wb_enable_d = (sel_addr != ADDR_W'(R0_ADDR));
            wb_addr_d   = sel_addr;
            wb_data_d   = sel_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RUN;
            rr_ptr_q    <= '0;
            wb_enable_q <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            wb_enable_q <= wb_enable_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
        end
    end

    assign wb_enable  = wb_enable_q;
    assign wb_addr    = wb_addr_q;
    assign wb_data    = wb_data_q;
    assign rel_enable = wb_enable_q;
    assign rel_addr   = wb_addr_q;
    assign drain_done = (state_q == HALTED);

`ifdef REGWB_PERF_CNT_EN
    logic [NUM_REQ-1:0][PERF_W-1:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_valid[k] && !req_ready[k] && (perf_q[k] != '1))
                perf_d[k] = perf_q[k] + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) perf_q <= '0;
        else          perf_q <= perf_d;
    end

    assign perf_stall_cnt = perf_q;
`else
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed table-driven bench for regfile_wb_arbiter (3 requesters, PERF_W=4).
module tb_regfile_wb_arbiter;

    localparam int NR = 3;
    localparam int AW = 5;
    localparam int DW = 48;
    localparam int PW = 4;

    localparam logic [DW-1:0] D0 = 48'h100;
    localparam logic [DW-1:0] D1 = 48'h101;
    localparam logic [DW-1:0] D2 = 48'h102;
    localparam logic [DW-1:0] DA = 48'h0A0A_0A0A_0A0A;
    localparam logic [DW-1:0] DB = 48'h0B0B_0B0B_0B0B;
    localparam logic [DW-1:0] DR0 = 48'h123;

    logic                 clk, reset_n;
    logic [NR-1:0]        req_valid, req_ready;
    logic [NR*AW-1:0]     req_addr;
    logic [NR*DW-1:0]     req_data;
    logic                 drain_req, drain_done;
    logic                 wb_enable, rel_enable;
    logic [AW-1:0]        wb_addr, rel_addr;
    logic [DW-1:0]        wb_data;
    logic [NR*PW-1:0]     perf_stall_cnt;

    int n_chk = 0;
    int n_fail = 0;

    regfile_wb_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .PERF_W(PW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .drain_req      (drain_req),
        .drain_done     (drain_done),
        .wb_enable      (wb_enable),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .rel_enable     (rel_enable),
        .rel_addr       (rel_addr),
        .perf_stall_cnt (perf_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach summary");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [NR-1:0]    valid;
        logic [NR*AW-1:0] addr;
        logic [NR*DW-1:0] data;
        logic             drain;
        logic [NR-1:0]    e_ready;
        logic             e_en;
        logic [AW-1:0]    e_addr;
        logic [DW-1:0]    e_data;
        logic             e_dd;
    } vec_t;

    function automatic logic [NR*AW-1:0] pa(input logic [AW-1:0] a0, a1, a2);
        return {a2, a1, a0};
    endfunction

    function automatic logic [NR*DW-1:0] pd(input logic [DW-1:0] d0, d1, d2);
        return {d2, d1, d0};
    endfunction

    function automatic vec_t mk(input logic [NR-1:0] v, input logic [NR*AW-1:0] a,
                                input logic [NR*DW-1:0] d, input logic dr,
                                input logic [NR-1:0] er, input logic een,
                                input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                                input logic edd);
        vec_t t;
        t.valid = v; t.addr = a; t.data = d; t.drain = dr;
        t.e_ready = er; t.e_en = een; t.e_addr = ea; t.e_data = ed; t.e_dd = edd;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string pfx, input logic en, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic dd);
        chk({pfx, "_wb_en"},  64'(wb_enable),  64'(en));
        chk({pfx, "_wb_addr"}, 64'(wb_addr),   64'(a));
        chk({pfx, "_wb_data"}, 64'(wb_data),   64'(d));
        chk({pfx, "_rel_en"}, 64'(rel_enable), 64'(en));
        chk({pfx, "_rel_addr"}, 64'(rel_addr), 64'(a));
        chk({pfx, "_drain_done"}, 64'(drain_done), 64'(dd));
    endtask

    vec_t vecs[14];
    logic [NR*AW-1:0] a567;
    logic [NR*DW-1:0] dflt;
    logic [NR*PW-1:0] perf_exp;

    initial begin
        a567 = pa(5'd5, 5'd6, 5'd7);
        dflt = pd(D0, D1, D2);
        // round robin 0,1,2,0 then idle
        vecs[0]  = mk(3'b111, a567, dflt, 1'b0, 3'b001, 1'b1, 5'd5, D0, 1'b0);
        vecs[1]  = mk(3'b111, a567, dflt, 1'b0, 3'b010, 1'b1, 5'd6, D1, 1'b0);
        vecs[2]  = mk(3'b111, a567, dflt, 1'b0, 3'b100, 1'b1, 5'd7, D2, 1'b0);
        vecs[3]  = mk(3'b111, a567, dflt, 1'b0, 3'b001, 1'b1, 5'd5, D0, 1'b0);
        vecs[4]  = mk(3'b000, a567, dflt, 1'b0, 3'b000, 1'b0, 5'd5, D0, 1'b0);
        // requester 1 writes R0: granted, no strobe, addr/data still update
        vecs[5]  = mk(3'b010, pa(5'd5, 5'd0, 5'd7), pd(D0, DR0, D2), 1'b0,
                      3'b010, 1'b0, 5'd0, DR0, 1'b0);
        // same address from 0 and 2 with ptr=2: B then A
        vecs[6]  = mk(3'b101, pa(5'd9, 5'd6, 5'd9), pd(DA, D1, DB), 1'b0,
                      3'b100, 1'b1, 5'd9, DB, 1'b0);
        vecs[7]  = mk(3'b001, pa(5'd9, 5'd6, 5'd9), pd(DA, D1, DB), 1'b0,
                      3'b001, 1'b1, 5'd9, DA, 1'b0);
        vecs[8]  = mk(3'b111, a567, dflt, 1'b0, 3'b010, 1'b1, 5'd6, D1, 1'b0);
        // drain raised in cycle N, halted from N+2, resume after release
        vecs[9]  = mk(3'b111, a567, dflt, 1'b1, 3'b000, 1'b0, 5'd6, D1, 1'b0);
        vecs[10] = mk(3'b111, a567, dflt, 1'b1, 3'b000, 1'b0, 5'd6, D1, 1'b1);
        vecs[11] = mk(3'b111, a567, dflt, 1'b1, 3'b000, 1'b0, 5'd6, D1, 1'b1);
        vecs[12] = mk(3'b111, a567, dflt, 1'b0, 3'b000, 1'b0, 5'd6, D1, 1'b0);
        vecs[13] = mk(3'b111, a567, dflt, 1'b0, 3'b100, 1'b1, 5'd7, D2, 1'b0);

        reset_n = 1'b0; req_valid = '0; req_addr = '0; req_data = '0; drain_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 1'b0, 5'd0, 48'h0, 1'b0);
        chk("reset_ready", 64'(req_ready), 64'h0);
        reset_n = 1'b1;

        for (int v = 0; v < 14; v++) begin
            req_valid = vecs[v].valid;
            req_addr  = vecs[v].addr;
            req_data  = vecs[v].data;
            drain_req = vecs[v].drain;
            #1;
            chk($sformatf("v%0d_ready", v), 64'(req_ready), 64'(vecs[v].e_ready));
            @(posedge clk); #1;
            chk_out($sformatf("v%0d", v), vecs[v].e_en, vecs[v].e_addr,
                    vecs[v].e_data, vecs[v].e_dd);
        end

        // async reset while HALTED clears drain_done before any edge
        req_valid = '0; drain_req = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        chk("halt_dd", 64'(drain_done), 64'h1);
        #2 reset_n = 1'b0;
        #1 chk("rst_async_dd", 64'(drain_done), 64'h0);
        @(posedge clk); #1;
        reset_n = 1'b1; drain_req = 1'b0;
        req_valid = 3'b111; req_addr = a567; req_data = dflt;
        #1 chk("post_rst1_ready", 64'(req_ready), 64'h1);
        @(posedge clk); #1;
        chk("pre_rst_wb_en", 64'(wb_enable), 64'h1);
        // async reset while a write is on the port
        req_valid = '0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_wb_en", 64'(wb_enable), 64'h0);
        chk("rst_async_rel_en", 64'(rel_enable), 64'h0);
        chk("rst_async_wb_addr", 64'(wb_addr), 64'h0);
        chk("rst_async_wb_data", 64'(wb_data), 64'h0);
        @(posedge clk); #1;
        reset_n = 1'b1; req_valid = 3'b111;
        #1 chk("post_rst2_ready", 64'(req_ready), 64'h1);
        @(posedge clk); #1;
        chk_out("post_rst2", 1'b1, 5'd5, D0, 1'b0);

        // stall counters: requester 2 blocked by drain for 20 cycles
        req_valid = '0; drain_req = 1'b0;
        #1 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        chk("perf_reset", 64'(perf_stall_cnt), 64'h0);
        req_valid = 3'b100; drain_req = 1'b1;
        repeat (20) @(posedge clk);
        #1;
`ifdef REGWB_PERF_CNT_EN
        perf_exp = {4'hF, 4'h0, 4'h0};
`else
        perf_exp = '0;
`endif
        chk("perf_sat", 64'(perf_stall_cnt), 64'(perf_exp));
        chk("perf_ready", 64'(req_ready), 64'h0);
        repeat (2) @(posedge clk);
        #1 chk("perf_hold", 64'(perf_stall_cnt), 64'(perf_exp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
